// File: rtl/famicom_pkg.sv
// famicom_pkg
//   Shared types and constants for the Famicom/NES pad reader.
//   - state_t        : frame sequencer states
//   - DEF_*          : default timing / width parameters (50 MHz clk_sys, 60 Hz polling, NES pad)
//   - BTN_*          : bit positions of the NES buttons in the buttons vector
package famicom_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    DONE  = 3'd4
  } state_t;

  // 6 us half-period at 50 MHz, 60 Hz frame rate, 8 buttons
  localparam int DEF_TICK_CYCLES = 300;
  localparam int DEF_POLL_CYCLES = 833333;
  localparam int DEF_NUM_BITS    = 8;

  // NES serial order: first bit shifted out of the pad is A
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input.
//   Ports:
//     clk_sys : destination clock
//     reset   : synchronous, active-high; both flops load RST_VAL
//     d       : asynchronous input
//     q       : synchronized output (2-cycle latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/famicom_pad_reader.sv
// famicom_pad_reader
//   Host-side initiator for the Famicom/NES serial pad protocol. Periodically
//   pulses latch, then clocks NUM_BITS+1 bits out of a 4021-style shift
//   register in the pad. The extra final bit detects presence: a connected pad
//   shifts in a driven low, a floating (pulled-up) line reads high.
//   Ports:
//     clk_sys       : system clock
//     reset         : synchronous, active-high
//     enable        : 1 = poll periodically; 0 = finish current frame, then idle
//     pad_latch     : to pad, parallel-load strobe (registered)
//     pad_pulse     : to pad, shift clock, pad shifts on rising edge (registered)
//     pad_data      : from pad, asynchronous, low = pressed
//     buttons       : bit i = i-th serial bit, 1 = pressed
//     buttons_valid : one-cycle strobe, buttons/pad_connected update with it
//     pad_connected : controller seen in the last completed frame
//     busy          : frame in progress (registered)
module famicom_pad_reader
  import famicom_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int POLL_CYCLES = DEF_POLL_CYCLES,
  parameter int NUM_BITS    = DEF_NUM_BITS
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                enable,
  output logic                pad_latch,
  output logic                pad_pulse,
  input  logic                pad_data,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_valid,
  output logic                pad_connected,
  output logic                busy
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int KW = $clog2(NUM_BITS + 1);

  // ---------------------------------------------------------------------
  // Input synchronizer; idle-high so reset looks like "no pad"
  // ---------------------------------------------------------------------
  logic data_sync;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (pad_data),
    .q       (data_sync)
  );

  // ---------------------------------------------------------------------
  // Poll counter: free-runs while enabled, even during a frame, so frame
  // starts stay exactly POLL_CYCLES apart.
  // ---------------------------------------------------------------------
  logic [PW-1:0] poll_cnt;
  logic          poll_last;

  assign poll_last = (poll_cnt == PW'(POLL_CYCLES - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || !enable)
      poll_cnt <= '0;
    else if (poll_last)
      poll_cnt <= '0;
    else
      poll_cnt <= poll_cnt + PW'(1);
  end

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  state_t state, next_state;

  always_ff @(posedge clk_sys) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // ---------------------------------------------------------------------
  // Tick timing. The counter restarts on every state entry. LATCH spans two
  // ticks; latch_half marks that the first one has elapsed.
  // ---------------------------------------------------------------------
  logic [TW-1:0] tick_cnt;
  logic          tick_last;
  logic          latch_half;
  logic          state_change;
  logic [KW-1:0] k;

  assign tick_last    = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign state_change = (next_state != state);

  always_ff @(posedge clk_sys) begin
    if (reset || state_change)
      tick_cnt <= '0;
    else if (tick_last)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset || state_change)
      latch_half <= 1'b0;
    else if (state == LATCH && tick_last)
      latch_half <= 1'b1;
  end

  // ---------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (enable && poll_last)     next_state = LATCH;
      LATCH:   if (tick_last && latch_half) next_state = LO;
      LO:      if (tick_last)               next_state = (k == KW'(NUM_BITS)) ? DONE : HI;
      HI:      if (tick_last)               next_state = LO;
      DONE:                                 next_state = IDLE;
      default:                              next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM outputs: decoded from next_state and registered so the pins change
  // exactly on state entry, glitch-free.
  // ---------------------------------------------------------------------
  logic latch_d, pulse_d, busy_d;

  always_comb begin
    latch_d = 1'b0;
    pulse_d = 1'b0;
    busy_d  = 1'b1;
    unique case (next_state)
      IDLE:    busy_d  = 1'b0;
      LATCH:   latch_d = 1'b1;
      HI:      pulse_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pad_latch <= 1'b0;
      pad_pulse <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pad_latch <= latch_d;
      pad_pulse <= pulse_d;
      busy      <= busy_d;
    end
  end

  // ---------------------------------------------------------------------
  // Bit index and capture register. Bit NUM_BITS is the presence bit.
  // Sampling happens at the end of each LO tick, well after the pad has
  // shifted on the previous pulse edge (or been loaded by latch).
  // ---------------------------------------------------------------------
  logic [NUM_BITS:0] shift;

  always_ff @(posedge clk_sys) begin
    if (reset)
      k <= '0;
    else if (state == LATCH)
      k <= '0;
    else if (state == HI && tick_last)
      k <= k + KW'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      shift <= '0;
    else if (state == LO && tick_last)
      shift[k] <= ~data_sync;
  end

  // ---------------------------------------------------------------------
  // Result registers: whole-vector update in DONE, strobe alongside it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      buttons       <= '0;
      pad_connected <= 1'b0;
      buttons_valid <= 1'b0;
    end else begin
      buttons_valid <= (state == DONE);
      if (state == DONE) begin
        buttons       <= shift[NUM_BITS-1:0];
        pad_connected <= shift[NUM_BITS];
      end
    end
  end

endmodule

// File: tb/tb_famicom_pad_reader.sv
module tb_famicom_pad_reader;

  localparam int TICK = 4;
  localparam int POLL = 200;
  localparam int NB   = 8;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          enable  = 1'b0;
  logic          pad_latch, pad_pulse, pad_data;
  logic [NB-1:0] buttons;
  logic          buttons_valid, pad_connected, busy;

  always #5 clk_sys = ~clk_sys;

  famicom_pad_reader #(.TICK_CYCLES(TICK), .POLL_CYCLES(POLL), .NUM_BITS(NB)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .enable        (enable),
    .pad_latch     (pad_latch),
    .pad_pulse     (pad_pulse),
    .pad_data      (pad_data),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .pad_connected (pad_connected),
    .busy          (busy)
  );

  // ---------------- pad model: 4021, serial-in pulled high ----------------
  logic [7:0]  pad_raw     = 8'hFF;   // low = pressed
  bit          pad_present = 1'b1;
  logic [15:0] sr          = '1;
  logic        pulse_q     = 1'b0;
  logic        latch_q     = 1'b0;
  logic [8:0]  exp_q[$];              // {connected, buttons}

  assign pad_data = pad_present ? sr[0] : 1'b1;

  always @(negedge clk_sys) begin
    if (pad_latch === 1'b1) sr <= {8'h00, pad_raw};
    else if (pad_pulse === 1'b1 && pulse_q == 1'b0) sr <= {1'b1, sr[15:1]};
    pulse_q <= (pad_pulse === 1'b1);
    if (pad_latch === 1'b1 && latch_q == 1'b0)
      exp_q.push_back(pad_present ? {1'b1, ~pad_raw} : 9'h000);
    latch_q <= (pad_latch === 1'b1);
  end

  // ---------------- monitor: per-frame statistics between strobes ----------------
  int   cyc = 0, acc_busy = 0, acc_latch = 0, acc_pedge = 0;
  int   f_busy = 0, f_latch = 0, f_pedge = 0, f_period = 0, last_strobe = 0;
  int   strobes = 0, latch_rises = 0, glitches = 0, viol = 0;
  logic mp_q = 1'b0, ml_q = 1'b0;
  logic [NB-1:0] btn_q = '0;

  always @(negedge clk_sys) begin
    cyc++;
    if (pad_pulse === 1'b1 && !mp_q && pad_latch === 1'b1) viol++;
    if (pad_latch === 1'b1 && !ml_q) latch_rises++;
    if (!reset && buttons_valid !== 1'b1 && buttons !== btn_q) glitches++;
    if (buttons_valid === 1'b1) begin
      f_busy = acc_busy; f_latch = acc_latch; f_pedge = acc_pedge;
      f_period = cyc - last_strobe; last_strobe = cyc; strobes++;
      acc_busy = 0; acc_latch = 0; acc_pedge = 0;
    end else begin
      if (busy === 1'b1) acc_busy++;
      if (pad_latch === 1'b1) acc_latch++;
      if (pad_pulse === 1'b1 && !mp_q) acc_pedge++;
    end
    mp_q  = (pad_pulse === 1'b1);
    ml_q  = (pad_latch === 1'b1);
    btn_q = buttons;
  end

  int errors = 0, checks = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (buttons_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_high_pulse(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (pad_pulse === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_high_latch(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (pad_latch === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; enable = 1'b0;
    tick(3);
    checks++;
    if ({pad_latch, pad_pulse, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: latch/pulse/busy=%b need 000", {pad_latch, pad_pulse, busy});
    end
    checks++;
    if ({buttons_valid, pad_connected} !== 2'b00) begin
      errors++; $display("FAIL reset_status: valid/connected=%b need 00", {buttons_valid, pad_connected});
    end
    checks++;
    if (buttons !== 8'h00) begin
      errors++; $display("FAIL reset_buttons: got %h need 00", buttons);
    end
    reset = 1'b0;
  endtask

  task automatic test_a_pressed;
    bit ok; logic [8:0] e;
    pad_present = 1'b1; pad_raw = 8'hFE; enable = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_valid(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL a_strobe%0d: no strobe within 400 cycles", f); end
      else begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL a_sb%0d: strobe with empty scoreboard", f); end
        else begin
          e = exp_q.pop_front();
          if ({pad_connected, buttons} !== e) begin
            errors++; $display("FAIL a_sb%0d: got %h need %h", f, {pad_connected, buttons}, e);
          end
        end
        checks++;
        if (buttons !== 8'h01 || pad_connected !== 1'b1) begin
          errors++; $display("FAIL a_value%0d: buttons=%h conn=%b need 01/1", f, buttons, pad_connected);
        end
      end
    end
    @(posedge clk_sys); #1;
    checks++;
    if (f_period != POLL) begin errors++; $display("FAIL a_period: got %0d need %0d", f_period, POLL); end
  endtask

  task automatic test_reset_mid;
    bit ok; int s0;
    wait_high_pulse(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_wait: no HI phase within 300 cycles"); end
    s0 = strobes;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    checks++;
    if ({pad_latch, pad_pulse, busy} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_ctrl: latch/pulse/busy=%b need 000", {pad_latch, pad_pulse, busy});
    end
    checks++;
    if (buttons !== 8'h00 || buttons_valid !== 1'b0 || pad_connected !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out: buttons=%h valid=%b conn=%b need 00/0/0", buttons, buttons_valid, pad_connected);
    end
    tick(4);
    reset = 1'b0;
    tick(100);
    checks++;
    if (strobes != s0) begin errors++; $display("FAIL rst_mid_strobe: got %0d strobes need 0", strobes - s0); end
    exp_q.delete();
  endtask

  task automatic test_all_pressed;
    bit ok; logic [8:0] e;
    pad_present = 1'b1; pad_raw = 8'h00;
    for (int f = 0; f < 2; f++) begin
      wait_valid(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL all_strobe%0d: no strobe within 400 cycles", f); end
      else begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL all_sb%0d: strobe with empty scoreboard", f); end
        else begin
          e = exp_q.pop_front();
          if ({pad_connected, buttons} !== e) begin
            errors++; $display("FAIL all_sb%0d: got %h need %h", f, {pad_connected, buttons}, e);
          end
        end
        checks++;
        if (buttons !== 8'hFF) begin errors++; $display("FAIL all_value%0d: got %h need FF", f, buttons); end
      end
    end
    @(posedge clk_sys); #1;
    checks++;
    if (f_pedge != NB) begin errors++; $display("FAIL all_pedges: got %0d need %0d", f_pedge, NB); end
    checks++;
    if (f_latch != 2*TICK) begin errors++; $display("FAIL all_latch_len: got %0d need %0d", f_latch, 2*TICK); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL all_pulse_in_latch: got %0d need 0", viol); end
  endtask

  task automatic test_no_pad;
    bit ok; logic [8:0] e;
    pad_present = 1'b0;
    for (int f = 0; f < 2; f++) begin
      wait_valid(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL nopad_strobe%0d: no strobe within 400 cycles", f); end
      else begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL nopad_sb%0d: strobe with empty scoreboard", f); end
        else begin
          e = exp_q.pop_front();
          if ({pad_connected, buttons} !== e) begin
            errors++; $display("FAIL nopad_sb%0d: got %h need %h", f, {pad_connected, buttons}, e);
          end
        end
        checks++;
        if (buttons !== 8'h00 || pad_connected !== 1'b0) begin
          errors++; $display("FAIL nopad_value%0d: buttons=%h conn=%b need 00/0", f, buttons, pad_connected);
        end
      end
    end
    @(posedge clk_sys); #1;
    checks++;
    if (f_busy != TICK*(2*NB+3)+1) begin
      errors++; $display("FAIL nopad_busy: got %0d need %0d", f_busy, TICK*(2*NB+3)+1);
    end
  endtask

  task automatic test_enable_drop;
    bit ok; logic [8:0] e; int lr; int n;
    pad_present = 1'b1; pad_raw = 8'hFD;
    wait_high_latch(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_wait: no latch within 300 cycles"); end
    tick(19);
    enable = 1'b0;
    wait_valid(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_strobe: frame did not complete within 100 cycles"); end
    else begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL drop_sb: strobe with empty scoreboard"); end
      else begin
        e = exp_q.pop_front();
        if ({pad_connected, buttons} !== e) begin
          errors++; $display("FAIL drop_sb: got %h need %h", {pad_connected, buttons}, e);
        end
      end
      checks++;
      if (buttons !== 8'h02) begin errors++; $display("FAIL drop_value: got %h need 02", buttons); end
    end
    lr = latch_rises;
    tick(400);
    checks++;
    if (latch_rises != lr || busy !== 1'b0) begin
      errors++; $display("FAIL drop_idle: latches=%0d busy=%b need 0/0", latch_rises - lr, busy);
    end
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_sys); #1;
      n++;
      if (pad_latch === 1'b1) break;
    end
    checks++;
    if (n != POLL) begin errors++; $display("FAIL drop_restart: first latch after %0d cycles need %0d", n, POLL); end
    wait_valid(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_restart_strobe: no strobe within 100 cycles"); end
    else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({pad_connected, buttons} !== e) begin
        errors++; $display("FAIL drop_restart_sb: got %h need %h", {pad_connected, buttons}, e);
      end
    end
  endtask

  task automatic test_snapshot;
    bit ok; logic [8:0] e; int g0;
    logic [7:0] need [3];
    need[0] = 8'h00; need[1] = 8'h00; need[2] = 8'h80;
    g0 = glitches;
    pad_present = 1'b1; pad_raw = 8'hFF;
    for (int f = 0; f < 3; f++) begin
      if (f == 1) begin
        wait_high_pulse(300, ok);
        tick(2);
        pad_raw = 8'h7F;   // change mid-shift; only the next latch sees it
      end
      wait_valid(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL snap_strobe%0d: no strobe within 400 cycles", f); end
      else begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL snap_sb%0d: strobe with empty scoreboard", f); end
        else begin
          e = exp_q.pop_front();
          if ({pad_connected, buttons} !== e) begin
            errors++; $display("FAIL snap_sb%0d: got %h need %h", f, {pad_connected, buttons}, e);
          end
        end
        checks++;
        if (buttons !== need[f]) begin errors++; $display("FAIL snap_value%0d: got %h need %h", f, buttons, need[f]); end
      end
    end
    checks++;
    if (glitches != g0) begin errors++; $display("FAIL snap_partial: %0d changes outside strobe need 0", glitches - g0); end
  endtask

  initial begin
    test_reset;
    test_a_pressed;
    test_reset_mid;
    test_all_pressed;
    test_no_pad;
    test_enable_drop;
    test_snapshot;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
